pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have these ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 stall  in  1  hazard hold; freezes PC and ID-stage PC.
REQ-004 halt  in  1  halt request from decode.
REQ-005 branch  in  1  taken-branch decision for the ID-stage instruction, from the branch logic.
REQ-006 offset_in  in  16  signed word offset for the taken branch, two's complement.
REQ-007 jr  in  1  jump-to-register request for the ID-stage instruction.
REQ-008 rs_value  in  32  jump-register target.
REQ-009 pc  out  32  fetch address, registered.
REQ-010 pc_id  out  32  PC of the instruction now in ID, registered.
REQ-011 fetch_valid  out  1  pc is a valid fetch this cycle.
REQ-012 flush  out  1  squash the IF/ID instruction this cycle.
REQ-013 halted  out  1  sequencer is in HALTED.

Function
REQ-014 The block SHALL have four states: IDLE, RUN, FLUSH and HALTED.
REQ-015 IDLE SHALL last exactly one cycle after reset: fetch_valid=0, pc unchanged, then go to RUN.
REQ-016 Priority in RUN SHALL be, highest first: halt > stall > jr > branch > sequential increment.
REQ-017 halt in RUN or FLUSH SHALL move the block to HALTED, freeze pc and pc_id, and give fetch_valid=0, halted=1; only rst leaves HALTED.
REQ-018 stall=1 in RUN SHALL hold pc, pc_id and state for that cycle, even when branch or jr is asserted.
REQ-019 jr=1 in RUN with no stall SHALL load pc <= rs_value and set state to FLUSH.
REQ-020 branch=1 in RUN with no stall or jr SHALL load pc <= pc_id + sign_extend(offset_in), modulo 2^32, and set state to FLUSH.
REQ-021 Otherwise RUN SHALL load pc <= pc + 1 (word addressing) and pc_id <= pc.
REQ-022 The pc + 1 update SHALL wrap 32'hFFFF_FFFF to 0 with no error indication.
REQ-023 On a redirect, pc_id SHALL be loaded with the old pc value, which is the squashed instruction.
REQ-024 FLUSH SHALL assert flush=1 and fetch_valid=1 for exactly one cycle, then return to RUN.
REQ-025 FLUSH SHALL ignore branch and jr, because they belong to the squashed instruction.
REQ-026 FLUSH SHALL honour stall: it holds in FLUSH with flush held at 1.
REQ-027 In FLUSH with no stall, the block SHALL load pc <= pc + 1 and pc_id <= pc.
REQ-028 Redirect latency SHALL be one cycle: the target appears on pc in the cycle after branch or jr is sampled.
REQ-029 fetch_valid SHALL be 1 only in RUN and FLUSH, and SHALL stay 1 in those states during stall.
REQ-030 All outputs SHALL be registered or decoded from state only, with no combinational input-to-output path.

Reset
REQ-031 On rst=1 at a rising edge, the block SHALL set pc=RESET_VECTOR (0), pc_id=0, fetch_valid=0, flush=0, halted=0 and state=IDLE.
REQ-032 rst SHALL override every other input and SHALL abort FLUSH or HALTED mid-operation.
REQ-033 Deasserting rst SHALL give one IDLE cycle, then RUN with pc=0 and fetch_valid=1.

Structure
REQ-034 A shared package SHALL hold the state enum, PC_WIDTH=32, OFF_WIDTH=16 and RESET_VECTOR=32'h0.
REQ-035 A single sub-module, pc_target_calc, SHALL do the 16-to-32 sign extension and modulo-2^32 add; the sequencer SHALL instantiate it once.

Verification
REQ-036 Reset and run: rst for 1 cycle, then free-run for 4 cycles -> one cycle with fetch_valid=0, then pc goes 0,1,2,3 and pc_id lags pc by one.
REQ-037 Taken branch: pc_id=5, branch=1, offset_in=16'hFFFC (-4) -> next pc=1, flush=1 for one cycle, then pc=2 with flush=0.
REQ-038 Jump register with branch: jr=1, rs_value=32'hFFFF_FFE0, branch=1, offset_in=4 -> pc=32'hFFFF_FFE0 (jr wins) and one flush cycle.
REQ-039 Stall priority: stall=1 with branch=1, offset_in=10, for 2 cycles -> pc, pc_id and state frozen with no flush; branch taken in the first unstalled cycle.
REQ-040 Wrap: pc=32'hFFFF_FFFF and idle inputs -> next pc=0 with no flush.
REQ-041 Halt and reset: halt=1 during FLUSH -> halted=1, fetch_valid=0 and pc frozen for 5 cycles; then rst -> all outputs at reset values, then IDLE, then RUN.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer slice: datapath
// widths, the reset vector and the sequencer state encoding.
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam int PC_WIDTH  = 32;
    localparam int OFF_WIDTH = 16;

    localparam logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;

    // IDLE   : single warm-up cycle after reset, nothing fetched
    // RUN    : normal sequential fetch, redirects accepted
    // FLUSH  : the instruction fetched behind a redirect is being squashed
    // HALTED : parked until reset
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
// Branch target adder: sign-extends a 16-bit word offset to 32 bits and adds
// it to the base PC, wrapping modulo 2^32.
//
// Ports
//   base   in  32  PC of the branching instruction (ID-stage PC)
//   offset in  16  signed word offset, two's complement
//   target out 32  base + sign_extend(offset), modulo 2^32
// ---------------------------------------------------------------------------
module pc_target_calc
    import pc_sequencer_pkg::*;
(
    input  logic [PC_WIDTH-1:0]  base,
    input  logic [OFF_WIDTH-1:0] offset,
    output logic [PC_WIDTH-1:0]  target
);

    logic [PC_WIDTH-1:0] offset_ext;

    // Replicate the offset sign bit into the upper half so negative offsets
    // subtract; carry out of bit 31 is simply dropped to wrap the address.
    always_comb begin
        offset_ext = {{(PC_WIDTH-OFF_WIDTH){offset[OFF_WIDTH-1]}}, offset};
        target     = base + offset_ext;
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Fetch-address sequencer for a simple pipeline. Walks the PC one word at a
// time, takes jump-register and branch redirects with one cycle of latency,
// squashes the wrongly fetched instruction behind a redirect, honours
// pipeline stalls and parks in HALTED until reset.
//
// Ports
//   clk         in  1   clock, all state updates on the rising edge
//   rst         in  1   synchronous active-high reset
//   stall       in  1   hazard hold, freezes pc and pc_id
//   halt        in  1   halt request from decode
//   branch      in  1   taken-branch decision for the ID-stage instruction
//   offset_in   in  16  signed word offset of the taken branch
//   jr          in  1   jump-to-register request for the ID-stage instruction
//   rs_value    in  32  jump-register target
//   pc          out 32  fetch address (registered)
//   pc_id       out 32  PC of the instruction now in ID (registered)
//   fetch_valid out 1   pc is a valid fetch this cycle (registered)
//   flush       out 1   squash the IF/ID instruction this cycle (registered)
//   halted      out 1   sequencer is in HALTED (registered)
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 branch,
    input  logic [OFF_WIDTH-1:0] offset_in,
    input  logic                 jr,
    input  logic [PC_WIDTH-1:0]  rs_value,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [PC_WIDTH-1:0]  pc_id,
    output logic                 fetch_valid,
    output logic                 flush,
    output logic                 halted
);

    seq_state_t          state;
    logic [PC_WIDTH-1:0] branch_target;

    // The branch target is relative to the instruction sitting in ID, not to
    // the current fetch address.
    pc_target_calc u_target_calc (
        .base   (pc_id),
        .offset (offset_in),
        .target (branch_target)
    );

    // Single state machine that owns the PC pair and every output flag. The
    // flags are assigned together with the next state so they always match
    // the state being entered, leaving no combinational path from any input
    // to any output. On a redirect pc_id takes the old pc, which is the
    // instruction being squashed during the following FLUSH cycle. In FLUSH
    // any branch/jr belongs to that squashed instruction and is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            pc_id       <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                    flush       <= 1'b0;
                    halted      <= 1'b0;
                end

                RUN: begin
                    if (halt) begin
                        state       <= HALTED;
                        fetch_valid <= 1'b0;
                        flush       <= 1'b0;
                        halted      <= 1'b1;
                    end else if (stall) begin
                        state <= RUN;
                    end else if (jr) begin
                        state <= FLUSH;
                        pc    <= rs_value;
                        pc_id <= pc;
                        flush <= 1'b1;
                    end else if (branch) begin
                        state <= FLUSH;
                        pc    <= branch_target;
                        pc_id <= pc;
                        flush <= 1'b1;
                    end else begin
                        pc    <= pc + PC_WIDTH'(1);
                        pc_id <= pc;
                    end
                end

                FLUSH: begin
                    if (halt) begin
                        state       <= HALTED;
                        fetch_valid <= 1'b0;
                        flush       <= 1'b0;
                        halted      <= 1'b1;
                    end else if (stall) begin
                        state <= FLUSH;
                    end else begin
                        state <= RUN;
                        pc    <= pc + PC_WIDTH'(1);
                        pc_id <= pc;
                        flush <= 1'b0;
                    end
                end

                HALTED: begin
                    state <= HALTED;
                end

                default: begin
                    state       <= IDLE;
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer: reset/run, taken branch, jr over branch,
// stall priority, stall during FLUSH, PC wrap, halt during FLUSH and reset
// out of HALTED. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        branch;
    logic [15:0] offset_in;
    logic        jr;
    logic [31:0] rs_value;
    logic [31:0] pc;
    logic [31:0] pc_id;
    logic        fetch_valid;
    logic        flush;
    logic        halted;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .halt        (halt),
        .branch      (branch),
        .offset_in   (offset_in),
        .jr          (jr),
        .rs_value    (rs_value),
        .pc          (pc),
        .pc_id       (pc_id),
        .fetch_valid (fetch_valid),
        .flush       (flush),
        .halted      (halted)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set every input for the next rising edge.
    task automatic apply_stimulus(input logic r, input logic s, input logic h,
                                  input logic b, input logic [15:0] off,
                                  input logic j, input logic [31:0] rs);
        rst       = r;
        stall     = s;
        halt      = h;
        branch    = b;
        offset_in = off;
        jr        = j;
        rs_value  = rs;
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare all five outputs against the expected values for this step.
    task automatic check_output(input string tag, input logic [31:0] exp_pc,
                                input logic [31:0] exp_pc_id, input logic exp_fv,
                                input logic exp_flush, input logic exp_halted);
        check_val({tag, ".pc"},          pc,                  exp_pc);
        check_val({tag, ".pc_id"},       pc_id,               exp_pc_id);
        check_val({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, exp_fv});
        check_val({tag, ".flush"},       {31'd0, flush},       {31'd0, exp_flush});
        check_val({tag, ".halted"},      {31'd0, halted},      {31'd0, exp_halted});
    endtask

    // Linear directed sequence; each step drives inputs, clocks once and
    // checks the registered outputs against hand-computed values.
    initial begin
        $display("[TB] pc_sequencer directed test start");
        apply_stimulus(1, 0, 0, 0, 16'h0, 0, 32'h0);
        step();
        check_output("reset", 32'h0, 32'h0, 0, 0, 0);

        // Leaving reset: the IDLE cycle above had fetch_valid=0, now RUN at 0.
        apply_stimulus(0, 0, 0, 0, 16'h0, 0, 32'h0);
        step();
        check_output("run0", 32'h0, 32'h0, 1, 0, 0);
        step();
        check_output("run1", 32'h1, 32'h0, 1, 0, 0);
        step();
        check_output("run2", 32'h2, 32'h1, 1, 0, 0);
        step();
        check_output("run3", 32'h3, 32'h2, 1, 0, 0);
        step();
        step();
        step();
        check_output("run6", 32'h6, 32'h5, 1, 0, 0);

        // Taken branch from pc_id=5 with offset -4 lands on 1.
        apply_stimulus(0, 0, 0, 1, 16'hFFFC, 0, 32'h0);
        step();
        check_output("br_redirect", 32'h1, 32'h6, 1, 1, 0);
        // Branch/jr during FLUSH belong to the squashed instruction.
        apply_stimulus(0, 0, 0, 1, 16'h0040, 1, 32'h0000_1234);
        step();
        check_output("br_after", 32'h2, 32'h1, 1, 0, 0);

        // jr outranks branch.
        apply_stimulus(0, 0, 0, 1, 16'h0004, 1, 32'hFFFF_FFE0);
        step();
        check_output("jr_redirect", 32'hFFFF_FFE0, 32'h2, 1, 1, 0);
        apply_stimulus(0, 0, 0, 0, 16'h0, 0, 32'h0);
        step();
        check_output("jr_after", 32'hFFFF_FFE1, 32'hFFFF_FFE0, 1, 0, 0);

        // Stall outranks branch for two cycles, then the branch is taken.
        apply_stimulus(0, 1, 0, 1, 16'd10, 0, 32'h0);
        step();
        check_output("stall1", 32'hFFFF_FFE1, 32'hFFFF_FFE0, 1, 0, 0);
        step();
        check_output("stall2", 32'hFFFF_FFE1, 32'hFFFF_FFE0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 16'd10, 0, 32'h0);
        step();
        check_output("stall_br", 32'hFFFF_FFEA, 32'hFFFF_FFE1, 1, 1, 0);
        apply_stimulus(0, 0, 0, 0, 16'h0, 0, 32'h0);
        step();
        check_output("stall_after", 32'hFFFF_FFEB, 32'hFFFF_FFEA, 1, 0, 0);

        // Stall inside FLUSH keeps flush asserted.
        apply_stimulus(0, 0, 0, 0, 16'h0, 1, 32'hFFFF_FFFE);
        step();
        check_output("fl_redirect", 32'hFFFF_FFFE, 32'hFFFF_FFEB, 1, 1, 0);
        apply_stimulus(0, 1, 0, 0, 16'h0, 0, 32'h0);
        step();
        check_output("fl_stall", 32'hFFFF_FFFE, 32'hFFFF_FFEB, 1, 1, 0);
        apply_stimulus(0, 0, 0, 0, 16'h0, 0, 32'h0);
        step();
        check_output("fl_release", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, 0);

        // Sequential increment wraps to zero silently.
        step();
        check_output("wrap", 32'h0, 32'hFFFF_FFFF, 1, 0, 0);

        // Halt during FLUSH parks the sequencer.
        apply_stimulus(0, 0, 0, 0, 16'h0, 1, 32'h0000_0100);
        step();
        check_output("h_redirect", 32'h100, 32'h0, 1, 1, 0);
        apply_stimulus(0, 0, 1, 0, 16'h0, 0, 32'h0);
        step();
        check_output("halt_enter", 32'h100, 32'h0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 1, 16'h0008, 1, 32'h0000_0BAD);
        for (int i = 0; i < 5; i++) begin
            step();
            check_output($sformatf("halt_hold%0d", i), 32'h100, 32'h0, 0, 0, 1);
        end

        // Reset leaves HALTED: reset values, IDLE, then RUN from 0.
        apply_stimulus(1, 0, 0, 0, 16'h0, 0, 32'h0);
        step();
        check_output("halt_reset", 32'h0, 32'h0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 16'h0, 0, 32'h0);
        step();
        check_output("rerun0", 32'h0, 32'h0, 1, 0, 0);
        step();
        check_output("rerun1", 32'h1, 32'h0, 1, 0, 0);

        // Halt in RUN outranks stall.
        apply_stimulus(0, 1, 1, 0, 16'h0, 0, 32'h0);
        step();
        check_output("halt_run", 32'h1, 32'h0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
